// File: rtl/operand_entry_controller.sv
// Multi-channel operand entry sequencer: edits the selected operand from Up/Down/Clear pulses and
// offers the full operand set downstream on a valid/ready handshake. Define SATURATE_EN to clamp at the range limits.
module operand_entry_controller #(
   parameter int SIZE     = 5,
   parameter int CHANNELS = 2,
   parameter     SIGNED   = "Yes",
   localparam int CW      = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS)
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       up,
   input  logic                       down,
   input  logic                       clear,
   input  logic                       next,
   input  logic                       commit,
   input  logic                       ready,
   output logic [CW-1:0]              channel,
   output logic [SIZE-1:0]            data,
   output logic [CHANNELS*SIZE-1:0]   operands,
   output logic                       valid
);

   localparam bit            IS_SIGNED = (SIGNED == "Yes");
   localparam logic [SIZE-1:0] MAX_V   = IS_SIGNED ? {1'b0, {(SIZE-1){1'b1}}} : {SIZE{1'b1}};
   localparam logic [SIZE-1:0] MIN_V   = IS_SIGNED ? {1'b1, {(SIZE-1){1'b0}}} : {SIZE{1'b0}};
   localparam logic [CW-1:0]   CH_LAST = CW'(CHANNELS - 1);

   typedef enum logic {EDIT, OFFER} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             channel_q, channel_d;
   logic [CHANNELS*SIZE-1:0]  operands_q, operands_d;
   logic [SIZE-1:0]           op_q [CHANNELS];
   logic [SIZE-1:0]           op_d [CHANNELS];

   // Both builds handle the range limits explicitly; only the limit behaviour differs.
   function automatic logic [SIZE-1:0] step_up(input logic [SIZE-1:0] v);
`ifdef SATURATE_EN
      return (v == MAX_V) ? MAX_V : v + SIZE'(1);
`else
      return (v == MAX_V) ? MIN_V : v + SIZE'(1);
`endif
   endfunction

   function automatic logic [SIZE-1:0] step_down(input logic [SIZE-1:0] v);
`ifdef SATURATE_EN
      return (v == MIN_V) ? MIN_V : v - SIZE'(1);
`else
      return (v == MIN_V) ? MAX_V : v - SIZE'(1);
`endif
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      channel_d  = channel_q;
      operands_d = operands_q;
      op_d       = op_q;
      case (state_q)
         EDIT: begin
            if (commit) begin
               for (int k = 0; k < CHANNELS; k++)
                  operands_d[k*SIZE +: SIZE] = op_q[k];
               state_d = OFFER;
            end else begin
               if (clear)
                  op_d[channel_q] = '0;
               else if (up && !down)
                  op_d[channel_q] = step_up(op_q[channel_q]);
               else if (down && !up)
                  op_d[channel_q] = step_down(op_q[channel_q]);
               if (next)
                  channel_d = (channel_q == CH_LAST) ? '0 : channel_q + CW'(1);
            end
         end
         OFFER: begin
            if (ready) begin
               state_d   = EDIT;
               channel_d = '0;
            end
         end
         default: state_d = EDIT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   // NOTE: the operand array is small register storage, so it is reset like any other flop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= EDIT;
         channel_q  <= '0;
         operands_q <= '0;
         for (int k = 0; k < CHANNELS; k++)
            op_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         channel_q  <= channel_d;
         operands_q <= operands_d;
         op_q       <= op_d;
      end
   end

   assign channel  = channel_q;
   assign data     = op_q[channel_q];
   assign operands = operands_q;
   assign valid    = (state_q == OFFER);

endmodule

// File: tb/tb_operand_entry_controller.sv
// Directed vector bench for operand_entry_controller (SIZE=5, CHANNELS=2, signed range).
module tb_operand_entry_controller;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       up, down, clear, next, commit, ready;
   logic [0:0] channel;
   logic [4:0] data;
   logic [9:0] operands;
   logic       valid;

   int n_vec = 0;
   int n_bad = 0;

   operand_entry_controller #(.SIZE(5), .CHANNELS(2), .SIGNED("Yes")) dut (
      .clock(clock), .reset_n(reset_n),
      .up(up), .down(down), .clear(clear), .next(next), .commit(commit), .ready(ready),
      .channel(channel), .data(data), .operands(operands), .valid(valid)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [5:0] in;      // {up, down, clear, next, commit, ready}
      logic       e_ch;
      logic [4:0] e_data;
      logic       e_valid;
      logic [9:0] e_ops;   // compared only while valid is expected
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic [5:0] in);
      {up, down, clear, next, commit, ready} = in;
      @(posedge clock);
      #1;
      {up, down, clear, next, commit, ready} = '0;
   endtask

   initial begin
      reset_n = 1'b0;
      {up, down, clear, next, commit, ready} = '0;

      //                name            u d c n m r  ch  data      v  ops
      vecs.push_back('{"t2_up1",      6'b100000, 0, 5'd1,     0, 10'd0});
      vecs.push_back('{"t2_up2",      6'b100000, 0, 5'd2,     0, 10'd0});
      vecs.push_back('{"t2_up3",      6'b100000, 0, 5'd3,     0, 10'd0});
      vecs.push_back('{"t2_next",     6'b000100, 1, 5'd0,     0, 10'd0});
      vecs.push_back('{"t2_dn1",      6'b010000, 1, 5'b11111, 0, 10'd0});
      vecs.push_back('{"t2_dn2",      6'b010000, 1, 5'b11110, 0, 10'd0});
      vecs.push_back('{"t2_commit",   6'b000010, 1, 5'b11110, 1, 10'b11110_00011});
      vecs.push_back('{"t4_hold_up",  6'b100000, 1, 5'b11110, 1, 10'b11110_00011});
      vecs.push_back('{"t4_hold_nx",  6'b000100, 1, 5'b11110, 1, 10'b11110_00011});
      vecs.push_back('{"t4_hold_cm",  6'b000010, 1, 5'b11110, 1, 10'b11110_00011});
      vecs.push_back('{"t4_hold_dn",  6'b010000, 1, 5'b11110, 1, 10'b11110_00011});
      vecs.push_back('{"t4_hold_cl",  6'b001000, 1, 5'b11110, 1, 10'b11110_00011});
      vecs.push_back('{"t4_accept",   6'b000001, 0, 5'd3,     0, 10'd0});
      vecs.push_back('{"t5_up_dn",    6'b110000, 0, 5'd3,     0, 10'd0});
      vecs.push_back('{"t5_clr_up",   6'b101000, 0, 5'd0,     0, 10'd0});
      vecs.push_back('{"t5_up_next",  6'b100100, 1, 5'b11110, 0, 10'd0});
      vecs.push_back('{"t5_wrap_ch",  6'b000100, 0, 5'd1,     0, 10'd0});
      vecs.push_back('{"t5_clr_next", 6'b001100, 1, 5'b11110, 0, 10'd0});
      vecs.push_back('{"t5_next",     6'b000100, 0, 5'd0,     0, 10'd0});
      vecs.push_back('{"t6_up",       6'b100000, 0, 5'd1,     0, 10'd0});
      vecs.push_back('{"t6_cmt_up",   6'b100010, 0, 5'd1,     1, 10'b11110_00001});
      vecs.push_back('{"t6_accept",   6'b000001, 0, 5'd1,     0, 10'd0});

      // Reset values while reset is held.
      #3;
      check("rst_channel", 32'(channel), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_operands", 32'(operands), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         cycle(vecs[i].in);
         check({vecs[i].name, "_ch"}, 32'(channel), 32'(vecs[i].e_ch));
         check({vecs[i].name, "_data"}, 32'(data), 32'(vecs[i].e_data));
         check({vecs[i].name, "_valid"}, 32'(valid), 32'(vecs[i].e_valid));
         if (vecs[i].e_valid)
            check({vecs[i].name, "_ops"}, 32'(operands), 32'(vecs[i].e_ops));
      end

      // T3: ch0 currently 1; walk it up to MAX, then step past it.
      for (int i = 0; i < 14; i++) cycle(6'b100000);
      check("t3_at_max", 32'(data), 32'd15);
      cycle(6'b100000);
`ifdef SATURATE_EN
      check("t3_up_at_max", 32'(data), 32'd15);
`else
      check("t3_up_at_max", 32'(data), 32'b10000);
`endif
      // Down at MIN, mirrored.
      cycle(6'b001000);
      for (int i = 0; i < 16; i++) cycle(6'b010000);
      check("t3_at_min", 32'(data), 32'b10000);
      cycle(6'b010000);
`ifdef SATURATE_EN
      check("t3_dn_at_min", 32'(data), 32'b10000);
`else
      check("t3_dn_at_min", 32'(data), 32'b01111);
`endif

      // T1: asynchronous reset in the middle of an OFFER cycle.
      cycle(6'b100100);                 // ch0 edited, channel -> 1
      cycle(6'b000010);
      check("t1_offer_valid", 32'(valid), 32'd1);
      check("t1_offer_ch", 32'(channel), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t1_async_valid", 32'(valid), 32'd0);
      check("t1_async_ch", 32'(channel), 32'd0);
      check("t1_async_data", 32'(data), 32'd0);
      check("t1_async_ops", 32'(operands), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      cycle(6'b100000);
      check("t1_after_rst", 32'(data), 32'd1);
      check("t1_after_rst_v", 32'(valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
